// File: rtl/npu_dot_sequencer.sv
// npu_dot_sequencer
// Drives operand pairs into a dual-multiply-add DSP, tracks its pipeline
// latency with a tag shift register, and accumulates the returned dout
// beats into one dot-product result per in_last-delimited vector.
// Optional feature macro: NPU_DOT_SAT_EN (saturating accumulate plus a
// sticky acc_sat output). The default build wraps modulo 2^ACC_W.
module npu_dot_sequencer #(
    parameter int DSP_LAT = 2,
    parameter int ACC_W   = 48,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [17:0]      in_a0,
    input  logic signed [17:0]      in_b0,
    input  logic signed [17:0]      in_a1,
    input  logic signed [17:0]      in_b1,
    input  logic                    in_last,
    output logic signed [17:0]      dsp_a0,
    output logic signed [17:0]      dsp_b0,
    output logic signed [17:0]      dsp_a1,
    output logic signed [17:0]      dsp_b1,
    output logic                    dsp_ce,
    output logic                    dsp_reset,
    input  logic signed [36:0]      dsp_dout,
    output logic                    acc_valid,
    input  logic                    acc_ready,
`ifdef NPU_DOT_SAT_EN
    output logic                    acc_sat,
`endif
    output logic signed [ACC_W-1:0] acc_data,
    output logic        [CNT_W-1:0] acc_beats
);

    typedef struct packed {
        logic v;
        logic last;
    } tag_t;

    typedef struct packed {
        logic signed [17:0] a0;
        logic signed [17:0] b0;
        logic signed [17:0] a1;
        logic signed [17:0] b1;
    } ops_t;

    logic                    advance;
    logic                    dsp_reset_q;
    ops_t                    ops_q, ops_d;
    tag_t                    op_tag_q, op_tag_d;
    tag_t                    tag_q [DSP_LAT];
    tag_t                    tag_d [DSP_LAT];
    tag_t                    exit_tag;
    logic signed [ACC_W-1:0] dout_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic        [CNT_W-1:0] cnt_inc;
    logic                    res_valid_q, res_valid_d;
    logic signed [ACC_W-1:0] res_data_q, res_data_d;
    logic        [CNT_W-1:0] res_beats_q, res_beats_d;
`ifdef NPU_DOT_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic        [ACC_W:0]   sum_wide;
    logic                    clip;
    logic                    sat_q, sat_d;
    logic                    res_sat_q, res_sat_d;
`endif

    // The whole pipeline (operands, tags, DSP via ce) moves only when the
    // result slot can take a new value; reset and the DSP reset hold it still.
    assign advance  = (!res_valid_q || acc_ready) && !reset && !dsp_reset_q;
    assign dsp_ce   = advance;
    assign in_ready = advance;

    assign exit_tag = tag_q[DSP_LAT-1];
    assign dout_ext = ACC_W'(dsp_dout);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    assign dsp_a0    = ops_q.a0;
    assign dsp_b0    = ops_q.b0;
    assign dsp_a1    = ops_q.a1;
    assign dsp_b1    = ops_q.b1;
    assign dsp_reset = dsp_reset_q;
    assign acc_valid = res_valid_q;
    assign acc_data  = res_data_q;
    assign acc_beats = res_beats_q;
`ifdef NPU_DOT_SAT_EN
    assign acc_sat   = res_sat_q;
`endif

    // Launch operands (or a zero bubble) and shift the tag alongside the DSP pipeline
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves a latch behind.
        ops_d    = ops_q;
        op_tag_d = op_tag_q;
        tag_d    = tag_q;
        if (advance) begin
            if (in_valid) begin
                ops_d.a0 = in_a0;
                ops_d.b0 = in_b0;
                ops_d.a1 = in_a1;
                ops_d.b1 = in_b1;
            end else begin
                ops_d = '0;
            end
            op_tag_d.v    = in_valid;
            op_tag_d.last = in_valid && in_last;
            tag_d[0]      = op_tag_q;
            for (int i = 1; i < DSP_LAT; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    // Add the sign-extended DSP result to the running sum (wrapping or clipping)
    always_comb begin
`ifdef NPU_DOT_SAT_EN
        sum_wide = {acc_q[ACC_W-1], acc_q} + {dout_ext[ACC_W-1], dout_ext};
        clip     = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (!clip) begin
            sum = sum_wide[ACC_W-1:0];
        end else if (sum_wide[ACC_W]) begin
            sum = ACC_MIN;
        end else begin
            sum = ACC_MAX;
        end
`else
        sum = acc_q + dout_ext;
`endif
    end

    // Fold valid exiting beats into the accumulator; a last beat loads the result slot
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q && !acc_ready;
        res_data_d  = res_data_q;
        res_beats_d = res_beats_q;
`ifdef NPU_DOT_SAT_EN
        sat_d       = sat_q;
        res_sat_d   = res_sat_q;
`endif
        if (advance && exit_tag.v) begin
            if (exit_tag.last) begin
                res_valid_d = 1'b1;
                res_data_d  = sum;
                res_beats_d = cnt_inc;
                acc_d       = '0;
                cnt_d       = '0;
`ifdef NPU_DOT_SAT_EN
                res_sat_d   = sat_q || clip;
                sat_d       = 1'b0;
`endif
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
`ifdef NPU_DOT_SAT_EN
                sat_d = sat_q || clip;
`endif
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (reset) begin
            dsp_reset_q <= 1'b1;
            ops_q       <= '0;
            op_tag_q    <= '0;
            // NOTE: every tag stage is cleared so beats in flight at reset are
            // discarded rather than accumulated into the next vector.
            for (int i = 0; i < DSP_LAT; i++) begin
                tag_q[i] <= '0;
            end
            acc_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_beats_q <= '0;
`ifdef NPU_DOT_SAT_EN
            sat_q       <= 1'b0;
            res_sat_q   <= 1'b0;
`endif
        end else begin
            dsp_reset_q <= 1'b0;
            ops_q       <= ops_d;
            op_tag_q    <= op_tag_d;
            tag_q       <= tag_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_beats_q <= res_beats_d;
`ifdef NPU_DOT_SAT_EN
            sat_q       <= sat_d;
            res_sat_q   <= res_sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_npu_dot_sequencer.sv
// Testbench for npu_dot_sequencer: behavioural DSP model, per-vector
// reference sums pushed to a scoreboard queue, monitor pops on handshakes.
module tb_npu_dot_sequencer;

    localparam int DSP_LAT = 3;
    localparam int ACC_W   = 37;
    localparam int CNT_W   = 16;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));
    localparam logic signed [17:0] NEG_MAX = -18'sd131072;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [17:0]      in_a0 = '0, in_b0 = '0, in_a1 = '0, in_b1 = '0;
    logic                    in_last = 1'b0;
    logic signed [17:0]      dsp_a0, dsp_b0, dsp_a1, dsp_b1;
    logic                    dsp_ce, dsp_reset;
    logic signed [36:0]      dsp_dout;
    logic                    acc_valid;
    logic                    acc_ready = 1'b0;
    logic signed [ACC_W-1:0] acc_data;
    logic        [CNT_W-1:0] acc_beats;
`ifdef NPU_DOT_SAT_EN
    logic                    acc_sat;
`endif

    npu_dot_sequencer #(.DSP_LAT(DSP_LAT), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a0(in_a0), .in_b0(in_b0), .in_a1(in_a1), .in_b1(in_b1), .in_last(in_last),
        .dsp_a0(dsp_a0), .dsp_b0(dsp_b0), .dsp_a1(dsp_a1), .dsp_b1(dsp_b1),
        .dsp_ce(dsp_ce), .dsp_reset(dsp_reset), .dsp_dout(dsp_dout),
        .acc_valid(acc_valid), .acc_ready(acc_ready),
`ifdef NPU_DOT_SAT_EN
        .acc_sat(acc_sat),
`endif
        .acc_data(acc_data), .acc_beats(acc_beats)
    );

    always #5 clk = ~clk;

    // Behavioural DSP: a0*b0 + a1*b1 appears DSP_LAT ce-qualified edges later
    logic signed [36:0] dsp_pipe [DSP_LAT];
    always_ff @(posedge clk) begin
        if (dsp_reset) begin
            for (int i = 0; i < DSP_LAT; i++) dsp_pipe[i] <= '0;
        end else if (dsp_ce) begin
            dsp_pipe[0] <= 37'(longint'(dsp_a0) * longint'(dsp_b0) + longint'(dsp_a1) * longint'(dsp_b1));
            for (int i = 1; i < DSP_LAT; i++) dsp_pipe[i] <= dsp_pipe[i-1];
        end
    end
    assign dsp_dout = dsp_pipe[DSP_LAT-1];

    typedef struct {
        longint data;
        longint beats;
        bit     sat;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    longint cur_sum = 0;
    longint cur_beats = 0;
    bit     cur_sat = 1'b0;
    bit     ready_rand = 1'b0;
    bit     ready_force = 1'b1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
    endfunction

    // Reference model: running dot product of accepted beats
    task automatic model_beat(input longint p, input bit last);
        exp_t e;
        cur_sum = cur_sum + p;
        cur_beats++;
`ifdef NPU_DOT_SAT_EN
        if (cur_sum > ACC_MAX) begin
            cur_sum = ACC_MAX;
            cur_sat = 1'b1;
        end else if (cur_sum < ACC_MIN) begin
            cur_sum = ACC_MIN;
            cur_sat = 1'b1;
        end
`else
        cur_sum = wrap_acc(cur_sum);
`endif
        if (last) begin
            e.data  = cur_sum;
            e.beats = cur_beats % (longint'(1) << CNT_W);
            e.sat   = cur_sat;
            exp_q.push_back(e);
            cur_sum   = 0;
            cur_beats = 0;
            cur_sat   = 1'b0;
        end
    endtask

    task automatic send_beat(input logic signed [17:0] a0, input logic signed [17:0] b0,
                             input logic signed [17:0] a1, input logic signed [17:0] b1,
                             input bit last, output int tries);
        bit done = 1'b0;
        tries = 0;
        while (!done && tries < 200) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a0 = a0; in_b0 = b0; in_a1 = a1; in_b1 = b1;
            in_last = last;
            #1;
            tries++;
            if (in_ready) done = 1'b1;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        if (done) model_beat(longint'(a0) * longint'(b0) + longint'(a1) * longint'(b1), last);
        else check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_empty", longint'(exp_q.size()), 0);
    endtask

    // Result consumer
    initial begin
        forever begin
            @(negedge clk);
            acc_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: pop an expected result on every output handshake
    bit     prev_pend = 1'b0;
    longint prev_data = 0;
    longint prev_beats = 0;
    exp_t   mon_e;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    check("hold_valid", longint'(acc_valid), 1);
                    check("hold_data", longint'(acc_data), prev_data);
                    check("hold_beats", longint'(acc_beats), prev_beats);
                end
                if (acc_valid && acc_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", longint'(acc_valid), 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("acc_data", longint'(acc_data), mon_e.data);
                        check("acc_beats", longint'(acc_beats), mon_e.beats);
`ifdef NPU_DOT_SAT_EN
                        check("acc_sat", longint'(acc_sat), longint'(mon_e.sat));
`endif
                    end
                end
                prev_pend  = acc_valid && !acc_ready;
                prev_data  = longint'(acc_data);
                prev_beats = longint'(acc_beats);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // Stimulus
    initial begin
        int t;
        int k;
        logic signed [17:0] r0, r1, r2, r3;

        // Reset held for 5 cycles
        repeat (5) begin
            @(negedge clk);
            #2;
            check("rst_in_ready", longint'(in_ready), 0);
            check("rst_dsp_ce", longint'(dsp_ce), 0);
            check("rst_dsp_reset", longint'(dsp_reset), 1);
            check("rst_acc_valid", longint'(acc_valid), 0);
            check("rst_acc_data", longint'(acc_data), 0);
            check("rst_acc_beats", longint'(acc_beats), 0);
            check("rst_dsp_a0", longint'(dsp_a0), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("rel_dsp_reset_still_high", longint'(dsp_reset), 1);
        check("rel_in_ready_low", longint'(in_ready), 0);
        @(negedge clk);
        #2;
        check("rel_dsp_reset_low", longint'(dsp_reset), 0);
        check("rel_in_ready_high", longint'(in_ready), 1);

        // Single beat: result 14, latency DSP_LAT+1
        send_beat(18'sd1, 18'sd2, 18'sd3, 18'sd4, 1'b1, t);
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            in_valid = 1'b0;
            #2;
            if (acc_valid) break;
            k++;
        end
        check("single_latency", longint'(k), longint'(DSP_LAT + 1));
        check("single_data", longint'(acc_data), 14);
        drain();

        // Four beats of -35, then two beats of 2, back to back
        for (int i = 0; i < 4; i++) begin
            send_beat(-18'sd5, 18'sd7, 18'sd0, 18'sd0, i == 3, t);
            check("b2b_no_bubble", longint'(t), 1);
        end
        for (int i = 0; i < 2; i++) begin
            send_beat(18'sd1, 18'sd1, 18'sd1, 18'sd1, i == 1, t);
            check("b2b_no_bubble", longint'(t), 1);
        end
        drain();

        // Back-pressure: result held 10 cycles while a beat waits
        ready_force = 1'b0;
        send_beat(18'sd3, 18'sd4, 18'sd0, 18'sd0, 1'b0, t);
        send_beat(18'sd5, 18'sd6, 18'sd0, 18'sd0, 1'b1, t);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            #2;
            if (acc_valid) break;
        end
        check("stall_result_seen", longint'(acc_valid), 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_a0 = 18'sd7; in_b0 = 18'sd1; in_a1 = 18'sd0; in_b1 = 18'sd0; in_last = 1'b1;
        repeat (10) begin
            #2;
            check("stall_in_ready", longint'(in_ready), 0);
            check("stall_dsp_ce", longint'(dsp_ce), 0);
            check("stall_acc_data", longint'(acc_data), 42);
            check("stall_acc_beats", longint'(acc_beats), 2);
            @(negedge clk);
        end
        #3;
        ready_force = 1'b1;
        send_beat(18'sd7, 18'sd1, 18'sd0, 18'sd0, 1'b1, t);
        drain();

        // Bubbles between valid beats
        send_beat(18'sd2, 18'sd3, 18'sd0, 18'sd0, 1'b0, t);
        idle(1);
        send_beat(18'sd2, 18'sd3, 18'sd0, 18'sd0, 1'b1, t);
        idle(1);
        drain();

        // Overflow: three beats of the largest product pair (2^35 each)
        for (int i = 0; i < 3; i++) send_beat(NEG_MAX, NEG_MAX, NEG_MAX, NEG_MAX, i == 2, t);
        for (int i = 0; i < 2; i++) send_beat(NEG_MAX, NEG_MAX, NEG_MAX, NEG_MAX, i == 1, t);
        drain();

        // Reset in the middle of a vector
        send_beat(18'sd100, 18'sd100, 18'sd0, 18'sd0, 1'b0, t);
        send_beat(18'sd100, 18'sd100, 18'sd0, 18'sd0, 1'b0, t);
        @(negedge clk);
        reset = 1'b1;
        cur_sum = 0;
        cur_beats = 0;
        cur_sat = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (DSP_LAT + 3) begin
            @(negedge clk);
            #2;
            check("midrst_no_result", longint'(acc_valid), 0);
        end
        send_beat(18'sd1, 18'sd2, 18'sd3, 18'sd4, 1'b1, t);
        drain();

        // Randomized vectors with bubbles and random back-pressure
        #3;
        ready_rand = 1'b1;
        for (int v = 0; v < 60; v++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                r0 = ($urandom_range(0, 7) == 0) ? NEG_MAX : 18'($urandom);
                r1 = 18'($urandom);
                r2 = 18'($urandom);
                r3 = ($urandom_range(0, 7) == 0) ? NEG_MAX : 18'($urandom);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send_beat(r0, r1, r2, r3, b == len - 1, t);
            end
        end
        ready_rand = 1'b0;
        ready_force = 1'b1;
        drain();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/npu_dot_sequencer.md
Name: npu_dot_sequencer

Overview:
- Initiator side of the Gowin_MULTADDALU interface: drives operand pairs and clock-enable into the dual-multiply-add DSP, tracks its pipeline latency, and accumulates returned dout beats into dot-product results.
- Sits between the NPU operand fetch stream (valid/ready) and the weight/activation MAC datapath.
- Emits one accumulated result per vector (in_last-delimited) on a valid/ready output.

Parameters:
- DSP_LAT, 2, dsp_ce-qualified cycles from operands driven to the matching dsp_dout; legal range 1..8.
- ACC_W, 48, accumulator/result width in bits; legal range 37..64.
- CNT_W, 16, width of the per-result beat counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- in_a0  in  18  signed operand a0
- in_b0  in  18  signed operand b0
- in_a1  in  18  signed operand a1
- in_b1  in  18  signed operand b1
- in_last  in  1  final beat of the current vector
- dsp_a0, dsp_b0, dsp_a1, dsp_b1  out  18 each  operands to DSP
- dsp_ce  out  1  DSP clock enable
- dsp_reset  out  1  DSP reset
- dsp_dout  in  37  signed DSP result a0*b0 + a1*b1
- acc_valid  out  1  result valid
- acc_ready  in  1  result consumer ready
- acc_data  out  ACC_W  signed dot-product result
- acc_beats  out  CNT_W  number of beats summed into acc_data

Behaviour:
- Reset is synchronous and active-high on clk; one clock domain only.
- During reset:
  - all outputs are 0 and dsp_reset = 1;
  - the tag pipeline, accumulator and beat counter are cleared.
- dsp_reset is the registered copy of reset; it deasserts one cycle after reset deasserts.
- advance = !acc_valid || acc_ready, forced to 0 while reset or dsp_reset is high.
- dsp_ce = advance and in_ready = advance, both combinational.
- When advance = 1:
  - dsp_a0..b1 take in_* if in_valid, else 0 (bubble).
  - Each beat pushes a tag {v = in_valid, last = in_valid && in_last} into a DSP_LAT-deep shift register.
- When advance = 0:
  - operand registers and the tag shift register hold;
  - the DSP is frozen via ce, so tag and dout alignment is preserved.
- At the tag pipeline exit, when advance && v:
  - sum = acc + sign_extend(dsp_dout, ACC_W);
  - beat counter increments.
- If the exiting tag also has last:
  - acc_data <= sum, acc_beats <= counter + 1, acc_valid <= 1;
  - acc and counter clear to 0.
- Otherwise acc <= sum.
- Bubble tags (v = 0) leave acc and counter unchanged.
- acc_valid clears on acc_valid && acc_ready unless a new result loads in the same cycle; a load takes priority and keeps acc_valid = 1.
- acc_data and acc_beats stay stable while acc_valid && !acc_ready.
- Throughput is one beat per cycle with acc_ready held high.
- Latency from the accepted in_last beat to acc_valid is DSP_LAT + 1 cycles, with no stalls.
- Overflow:
  - acc wraps modulo 2^ACC_W (two's complement);
  - the beat counter wraps modulo 2^CNT_W.
- in_last on a single-beat vector produces a result equal to that beat's dout.
- Reset mid-vector discards the partial acc and all in-flight tags; no result is emitted.

Optional Feature:
- Macro: NPU_DOT_SAT_EN.
- Defined:
  - the accumulate step saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
  - a sticky sat flag sets on any clipped beat in the vector;
  - the flag is exported as extra output acc_sat (1 bit), aligned with acc_data, and clears with acc.
- Undefined: wrap-around arithmetic; no acc_sat port.

Test Plan:
- Reset held 5 cycles, then released → all outputs 0 and dsp_reset = 1 during reset; dsp_reset = 0 one cycle after release; in_ready = 1.
- Single beat a0=1, b0=2, a1=3, b1=4, last=1, DSP model returns 14 → acc_data = 14, acc_beats = 1, acc_valid asserted DSP_LAT+1 cycles after the beat was accepted.
- Four back-to-back beats, each a0=-5, b0=7, a1=0, b1=0, last on beat 4 → acc_data = -140, acc_beats = 4; then two beats (1,1,1,1) → acc_data = 4, acc_beats = 2, issued on consecutive vectors without bubbles.
- Result pending with acc_ready = 0 for 10 cycles while inputs are valid → dsp_ce = 0 and in_ready = 0 throughout; acc_data stable; no beat lost or duplicated after acc_ready rises.
- Bubbles: in_valid toggling 1,0,1,0 with last on the 2nd valid beat, operands (2,3,0,0) → acc_data = 12, acc_beats = 2.
- Overflow with ACC_W = 37: repeated beats of max product pair → wraps without NPU_DOT_SAT_EN; with it, clips to 2^36-1 and acc_sat = 1; reset asserted mid-vector → no result emitted and the next vector starts from 0.
